// File: rtl/fpga_axil2apb_bridge.sv
// AXI4-Lite to APB bridge: one APB transfer in flight, alternating read/write priority
// and an ACCESS-phase timeout that terminates a stalled transfer with SLVERR.
module fpga_axil2apb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    output logic [1:0]  S_AXI_BRESP,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic [31:0] m_apb_paddr,
    output logic [2:0]  m_apb_pprot,
    output logic        m_apb_psel,
    output logic        m_apb_penable,
    output logic        m_apb_pwrite,
    output logic [31:0] m_apb_pwdata,
    output logic [3:0]  m_apb_pstrb,
    input  logic [31:0] m_apb_prdata,
    input  logic        m_apb_pready,
    input  logic        m_apb_pslverr
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    // Abort fires on the ACCESS cycle whose increment would reach TIMEOUT_CYCLES.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        is_write_q, is_write_d;
    logic        prio_wr_q, prio_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  prot_q, prot_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] tcnt_q, tcnt_d;

    logic wr_elig, rd_elig, take_wr, take_rd, resp_done;

    always_comb begin
        wr_elig   = (state_q == StIdle) && !core_rst && S_AXI_AWVALID && S_AXI_WVALID;
        rd_elig   = (state_q == StIdle) && !core_rst && S_AXI_ARVALID;
        take_wr   = wr_elig && (prio_wr_q || !rd_elig);
        take_rd   = rd_elig && !take_wr;
        resp_done = (state_q == StResp) &&
                    (is_write_q ? S_AXI_BREADY : S_AXI_RREADY);
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        prio_wr_d  = prio_wr_q;
        addr_d     = addr_q;
        prot_d     = prot_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            StIdle: begin
                if (take_wr) begin
                    state_d    = StSetup;
                    is_write_d = 1'b1;
                    addr_d     = S_AXI_AWADDR;
                    prot_d     = S_AXI_AWPROT;
                    wdata_d    = S_AXI_WDATA;
                    strb_d     = S_AXI_WSTRB;
                    tcnt_d     = '0;
                end else if (take_rd) begin
                    state_d    = StSetup;
                    is_write_d = 1'b0;
                    addr_d     = S_AXI_ARADDR;
                    prot_d     = S_AXI_ARPROT;
                    wdata_d    = '0;
                    strb_d     = '0;
                    tcnt_d     = '0;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (m_apb_pready) begin
                    state_d = StResp;
                    resp_d  = m_apb_pslverr ? 2'b10 : 2'b00;
                    rdata_d = is_write_q ? 32'h0 : m_apb_prdata;
                end else if (tcnt_q == TimeoutLast) begin
                    state_d = StResp;
                    resp_d  = 2'b10;
                    rdata_d = 32'h0;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            default: begin
                if (resp_done) begin
                    state_d   = StIdle;
                    prio_wr_d = !is_write_q;
                end
            end
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            prio_wr_q  <= 1'b1;
            addr_q     <= '0;
            prot_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            resp_q     <= '0;
            rdata_q    <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            prio_wr_q  <= prio_wr_d;
            addr_q     <= addr_d;
            prot_q     <= prot_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            tcnt_q     <= tcnt_d;
        end
    end

    always_comb begin
        S_AXI_AWREADY = take_wr;
        S_AXI_WREADY  = take_wr;
        S_AXI_ARREADY = take_rd;
        S_AXI_BVALID  = (state_q == StResp) && is_write_q;
        S_AXI_RVALID  = (state_q == StResp) && !is_write_q;
        S_AXI_BRESP   = S_AXI_BVALID ? resp_q : 2'b00;
        S_AXI_RRESP   = S_AXI_RVALID ? resp_q : 2'b00;
        S_AXI_RDATA   = S_AXI_RVALID ? rdata_q : 32'h0;
        m_apb_psel    = (state_q == StSetup) || (state_q == StAccess);
        m_apb_penable = (state_q == StAccess);
        m_apb_pwrite  = is_write_q;
        m_apb_paddr   = addr_q;
        m_apb_pprot   = prot_q;
        m_apb_pwdata  = wdata_q;
        m_apb_pstrb   = strb_q;
    end

endmodule

// File: tb/tb_fpga_axil2apb_bridge.sv
// Scoreboard bench for fpga_axil2apb_bridge: directed AXI-Lite traffic against a scripted
// APB completer; expected AXI responses are queued at issue and checked by a monitor.
module tb_fpga_axil2apb_bridge;

    logic        core_clk, core_rst;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic [31:0] m_apb_paddr, m_apb_pwdata, m_apb_prdata;
    logic [2:0]  m_apb_pprot;
    logic        m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pready, m_apb_pslverr;
    logic [3:0]  m_apb_pstrb;

    fpga_axil2apb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .m_apb_paddr(m_apb_paddr), .m_apb_pprot(m_apb_pprot),
        .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
        .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
        .m_apb_prdata(m_apb_prdata), .m_apb_pready(m_apb_pready),
        .m_apb_pslverr(m_apb_pslverr)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   wr_acc_cyc = 0, rd_acc_cyc = 0, resp_cyc = 0;

    // APB completer script and per-transfer observations
    int          cfg_wait = 0;
    bit          cfg_hang = 0;
    int          pen_cnt = 0;
    bit          unstable = 0;
    logic [31:0] ap_addr, ap_wdata;
    logic [3:0]  ap_strb;
    logic [2:0]  ap_prot;
    logic        ap_write;
    logic        ap_order[$];

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drop valids after their handshake cycle; record acceptance cycles
    initial begin
        logic aw_hs, ar_hs;
        forever begin
            @(negedge core_clk);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
            if (aw_hs) begin
                wr_acc_cyc = cyc;
                check("wready_with_awready", {63'h0, S_AXI_WREADY}, 64'h1);
            end
            if (ar_hs) rd_acc_cyc = cyc;
            @(posedge core_clk);
            #1;
            if (aw_hs) begin
                S_AXI_AWVALID = 1'b0;
                S_AXI_WVALID  = 1'b0;
            end
            if (ar_hs) S_AXI_ARVALID = 1'b0;
        end
    end

    // APB completer and observer
    initial begin
        m_apb_pready = 1'b0;
        forever begin
            @(negedge core_clk);
            if (m_apb_psel && !m_apb_penable) begin
                pen_cnt  = 0;
                unstable = 0;
                ap_addr  = m_apb_paddr;
                ap_wdata = m_apb_pwdata;
                ap_strb  = m_apb_pstrb;
                ap_prot  = m_apb_pprot;
                ap_write = m_apb_pwrite;
                ap_order.push_back(m_apb_pwrite);
                m_apb_pready = 1'b0;
            end else if (m_apb_psel && m_apb_penable) begin
                if (m_apb_paddr !== ap_addr || m_apb_pwdata !== ap_wdata ||
                    m_apb_pstrb !== ap_strb || m_apb_pprot !== ap_prot ||
                    m_apb_pwrite !== ap_write) unstable = 1;
                m_apb_pready = !cfg_hang && (pen_cnt == cfg_wait);
                pen_cnt++;
            end else begin
                m_apb_pready = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each B/R handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge core_clk);
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_b: got BRESP 0x%0h, expected no response",
                             S_AXI_BRESP);
                end else begin
                    e = exp_q.pop_front();
                    check("b_kind", 64'h1, {63'h0, e.wr});
                    check("bresp", {62'h0, S_AXI_BRESP}, {62'h0, e.resp});
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_r: got RDATA 0x%0h, expected no response",
                             S_AXI_RDATA);
                end else begin
                    e = exp_q.pop_front();
                    check("r_kind", 64'h0, {63'h0, e.wr});
                    check("rresp", {62'h0, S_AXI_RRESP}, {62'h0, e.resp});
                    check("rdata", {32'h0, S_AXI_RDATA}, {32'h0, e.data});
                end
            end
        end
    end

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [2:0] p, input logic [1:0] r);
        exp_q.push_back(exp_t'{wr: 1'b1, resp: r, data: 32'h0});
        S_AXI_AWADDR = a; S_AXI_AWPROT = p; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [2:0] p, input logic [1:0] r,
                              input logic [31:0] d);
        exp_q.push_back(exp_t'{wr: 1'b0, resp: r, data: d});
        S_AXI_ARADDR = a; S_AXI_ARPROT = p; S_AXI_ARVALID = 1'b1;
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge core_clk);
            #1;
            done = (exp_q.size() == 0) && !S_AXI_AWVALID && !S_AXI_ARVALID;
        end
        check(name, {63'h0, done}, 64'h1);
    endtask

    initial begin
        bit seen;
        core_rst = 1'b1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
        S_AXI_ARADDR = 0; S_AXI_ARPROT = 0;
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        m_apb_prdata = 32'h0; m_apb_pslverr = 1'b0;
        repeat (2) @(posedge core_clk);
        @(negedge core_clk);
        check("rst_axi", {23'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
              S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP}, 64'h0);
        check("rst_apb_data", {m_apb_paddr, m_apb_pwdata}, 64'h0);
        check("rst_apb_ctrl", {54'h0, m_apb_pprot, m_apb_psel, m_apb_penable, m_apb_pwrite,
              m_apb_pstrb}, 64'h0);
        @(posedge core_clk);
        #1 core_rst = 1'b0;

        // Single write, pready on first ACCESS cycle
        issue_write(32'h0000_0100, 32'h1234_5678, 4'hF, 3'b101, 2'b00);
        wait_done("done_wr1");
        check("wr1_paddr", {32'h0, ap_addr}, 64'h100);
        check("wr1_pstrb_pwdata", {28'h0, ap_strb, ap_wdata}, {28'h0, 4'hF, 32'h1234_5678});
        check("wr1_pprot_pwrite", {60'h0, ap_prot, ap_write}, {60'h0, 3'b101, 1'b1});
        check("wr1_penable_cycles", pen_cnt, 1);
        check("wr1_latency", resp_cyc - wr_acc_cyc, 3);
        check("wr1_stable", {63'h0, unstable}, 64'h0);

        // Read with three wait states
        cfg_wait = 3;
        m_apb_prdata = 32'hCAFE_F00D;
        issue_read(32'h0000_0200, 3'b010, 2'b00, 32'hCAFE_F00D);
        wait_done("done_rd1");
        check("rd1_paddr", {32'h0, ap_addr}, 64'h200);
        check("rd1_zero_wdata_strb", {28'h0, ap_strb, ap_wdata}, 64'h0);
        check("rd1_pwrite", {63'h0, ap_write}, 64'h0);
        check("rd1_penable_cycles", pen_cnt, 4);
        check("rd1_latency", resp_cyc - rd_acc_cyc, 6);
        check("rd1_stable", {63'h0, unstable}, 64'h0);

        // Two simultaneous write/read pairs: write first each time
        cfg_wait = 0;
        m_apb_prdata = 32'h5A5A_0001;
        for (int k = 0; k < 2; k++) begin
            ap_order.delete();
            issue_write(32'h0000_1000 + k, 32'hA000_0000 + k, 4'h3, 3'b000, 2'b00);
            issue_read(32'h0000_2000 + k, 3'b000, 2'b00, 32'h5A5A_0001);
            wait_done("done_pair");
            check("pair_order", {61'h0, ap_order.size() == 2, ap_order[0], ap_order[1]},
                  64'h6);
            check("pair_accept_order", {63'h0, rd_acc_cyc > wr_acc_cyc}, 64'h1);
        end

        // Timeout: completer never ready
        cfg_hang = 1;
        m_apb_prdata = 32'hDEAD_BEEF;
        issue_read(32'h0000_0300, 3'b000, 2'b10, 32'h0);
        wait_done("done_timeout");
        check("timeout_penable_cycles", pen_cnt, 8);
        cfg_hang = 0;

        // pready on the timeout cycle itself wins
        cfg_wait = 7;
        issue_read(32'h0000_0304, 3'b000, 2'b00, 32'hDEAD_BEEF);
        wait_done("done_edge");
        check("edge_penable_cycles", pen_cnt, 8);
        cfg_wait = 0;

        // pslverr write with BREADY held low: BVALID/BRESP must hold
        m_apb_pslverr = 1'b1;
        S_AXI_BREADY = 1'b0;
        issue_write(32'h0000_0400, 32'h0000_00FF, 4'h1, 3'b000, 2'b10);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge core_clk);
            #1 seen = S_AXI_BVALID;
        end
        check("bvalid_seen", {63'h0, seen}, 64'h1);
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        check("bvalid_held", {61'h0, S_AXI_BVALID, S_AXI_BRESP}, 64'h6);
        @(posedge core_clk);
        #1 S_AXI_BREADY = 1'b1;
        wait_done("done_slverr_wr");

        // pslverr read still returns captured prdata
        m_apb_prdata = 32'h0BAD_0BAD;
        issue_read(32'h0000_0404, 3'b000, 2'b10, 32'h0BAD_0BAD);
        wait_done("done_slverr_rd");
        m_apb_pslverr = 1'b0;

        // Reset during ACCESS drops the transfer silently
        cfg_hang = 1;
        issue_write(32'h0000_0500, 32'h1111_2222, 4'hF, 3'b000, 2'b00);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge core_clk);
            #1 seen = m_apb_penable;
        end
        check("rst_mid_access_reached", {63'h0, seen}, 64'h1);
        exp_q.delete();
        core_rst = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        check("rst_mid_outputs", {60'h0, m_apb_psel, m_apb_penable, S_AXI_BVALID,
              S_AXI_RVALID}, 64'h0);
        @(posedge core_clk);
        #1 core_rst = 1'b0;
        cfg_hang = 0;
        repeat (3) @(posedge core_clk);
        #1;
        issue_write(32'h0000_0600, 32'h0000_00A5, 4'h2, 3'b001, 2'b00);
        wait_done("done_after_rst");
        check("after_rst_paddr", {32'h0, ap_addr}, 64'h600);
        check("after_rst_latency", resp_cyc - wr_acc_cyc, 3);

        repeat (3) @(posedge core_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
